stream_mux_n: RTL

Parametrised N-to-1 packet stream multiplexer with valid/ready handshakes, a registered output stage and two arbitration modes: externally selected or round-robin. It merges NUM_CH independent producer streams, such as per-unit result or trace buses, onto one consumer bus. Once a channel is granted it holds the output until its packet ends (in_last), so packets are never interleaved.

---
 rtl/stream_mux_n_if.sv | 33 +++
 rtl/stream_mux_n.sv | 110 +++++++++++
 2 files changed

// File: rtl/stream_mux_n_if.sv
// Handshake bundle between NUM_CH producer streams, the stream multiplexer and
// its single consumer.
interface stream_mux_n_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 32
);
  localparam int SEL_WIDTH = $clog2(NUM_CH);

  logic                  mode;
  logic [SEL_WIDTH-1:0]  sel;
  logic [NUM_CH-1:0]     in_valid;
  logic [DATA_WIDTH-1:0] in_data [NUM_CH-1:0];
  logic [NUM_CH-1:0]     in_last;
  logic [NUM_CH-1:0]     in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  logic [SEL_WIDTH-1:0]  grant;
  logic                  busy;

  // The side that feeds producers/consumer and configures arbitration.
  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, grant, busy
  );

  // The multiplexer itself.
  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, grant, busy
  );
endinterface

// File: rtl/stream_mux_n.sv
// N-to-1 packet stream multiplexer: external-select or round-robin arbitration,
// packet-granular locking and a registered output stage.
module stream_mux_n #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 32
) (
  input logic           clk,
  input logic           rst,
  stream_mux_n_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(NUM_CH);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [SEL_WIDTH-1:0]  grant_q;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [SEL_WIDTH-1:0]  cand;
  logic                  cand_found;
  logic                  take;
  logic                  accept;
  logic [NUM_CH-1:0]     in_ready;
  logic                  busy;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;

  function automatic logic [SEL_WIDTH-1:0] wrap_idx(input logic [SEL_WIDTH-1:0] base,
                                                    input int k);
    int v;
    v = int'(base) + k;
    if (v >= NUM_CH) v = v - NUM_CH;
    return v[SEL_WIDTH-1:0];
  endfunction

  // Round-robin scans downward so the nearest channel after rr_ptr wins.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    if (!bus.mode) begin
      if (int'(bus.sel) < NUM_CH && bus.in_valid[bus.sel]) begin
        cand       = bus.sel;
        cand_found = 1'b1;
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        if (bus.in_valid[wrap_idx(rr_ptr, k)]) begin
          cand       = wrap_idx(rr_ptr, k);
          cand_found = 1'b1;
        end
      end
    end
  end

  assign take   = !out_valid_q || bus.out_ready;
  assign accept = (state == LOCKED) && !rst && bus.in_valid[grant_q] && take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= SEL_WIDTH'(NUM_CH - 1);
    end else begin
      state <= next_state;
      if (state == IDLE && cand_found) grant_q <= cand;
      if (accept && bus.in_last[grant_q]) rr_ptr <= grant_q;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cand_found) next_state = LOCKED;
      LOCKED:  if (accept && bus.in_last[grant_q]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    busy     = (state == LOCKED);
    if (!rst && state == LOCKED) in_ready[grant_q] = take;
  end

  // A drain and a new accept in the same cycle simply reload the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[grant_q];
      out_last_q  <= bus.in_last[grant_q];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy;
endmodule
